// File: rtl/sample_framer_if.sv
// Sample-in / frame-out handshake bundle for the sample framer.
// The framer uses the slave view; the producer/consumer side uses master.
interface sample_framer_if #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 8
);
  logic                    s_valid;
  logic                    s_ready;
  logic [WIDTH-1:0]        s_data;
  logic                    frame_valid;
  logic                    frame_ready;
  logic [SIZE*WIDTH-1:0]   frame_data;
  logic [7:0]              frame_seq;

  modport master (
    output s_valid, s_data, frame_ready,
    input  s_ready, frame_valid, frame_data, frame_seq
  );

  modport slave (
    input  s_valid, s_data, frame_ready,
    output s_ready, frame_valid, frame_data, frame_seq
  );
endinterface

// File: rtl/sample_framer.sv
// Collects a serial sample stream into SIZE-sample frames (oldest at index 0),
// emitting a new frame every HOP samples after the initial fill.
module sample_framer #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 8,
  parameter int HOP   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  sample_framer_if.slave  bus
);
  localparam int CW = $clog2(SIZE + 1);
  localparam int FW = SIZE * WIDTH;
  localparam logic [CW-1:0] FILL_LAST = CW'(SIZE - 1);
  localparam logic [CW-1:0] HOP_LAST  = CW'(HOP - 1);

  typedef enum logic [0:0] {ST_FILL = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   sh_q, sh_d;
  logic [FW-1:0]   frame_data_q, frame_data_d;
  logic            frame_valid_q, frame_valid_d;
  logic [7:0]      frame_seq_q, frame_seq_d;
  logic [FW-1:0]   sh_shift_s;
  logic            trig_pend_s;
  logic            s_ready_s;
  logic            accept_s;
  logic            trigger_s;

  // Whether the next accepted sample completes a frame
  always_comb begin
    trig_pend_s = 1'b0;
    case (state_q)
      ST_FILL: trig_pend_s = (cnt_q == FILL_LAST);
      ST_RUN:  trig_pend_s = (cnt_q == HOP_LAST);
      default: trig_pend_s = 1'b0;
    endcase
  end

  // Stall only the completing sample while an unconsumed frame is held
  assign s_ready_s  = !clear && !(frame_valid_q && !bus.frame_ready && trig_pend_s);
  assign accept_s   = bus.s_valid && s_ready_s;
  assign trigger_s  = accept_s && trig_pend_s;
  assign sh_shift_s = {bus.s_data, sh_q[FW-1:WIDTH]};

  // Next-state logic for counter, shift register and frame output
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sh_d          = sh_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    frame_seq_d   = frame_seq_q;
    if (clear) begin
      state_d       = ST_FILL;
      cnt_d         = {CW{1'b0}};
      frame_valid_d = 1'b0;
    end else begin
      if (accept_s) begin
        sh_d = sh_shift_s;
        if (trig_pend_s) begin
          state_d = ST_RUN;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        sh_d = sh_q;
      end
      // A trigger on the same edge as a consume keeps frame_valid high
      if (trigger_s) begin
        frame_data_d  = sh_shift_s;
        frame_valid_d = 1'b1;
        frame_seq_d   = frame_seq_q + 8'd1;
      end else if (frame_valid_q && bus.frame_ready) begin
        frame_valid_d = 1'b0;
      end else begin
        frame_valid_d = frame_valid_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FILL;
      cnt_q         <= {CW{1'b0}};
      sh_q          <= {FW{1'b0}};
      frame_data_q  <= {FW{1'b0}};
      frame_valid_q <= 1'b0;
      frame_seq_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_seq_q   <= frame_seq_d;
    end
  end

  assign bus.s_ready     = s_ready_s;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_data  = frame_data_q;
  assign bus.frame_seq   = frame_seq_q;
endmodule

// File: doc/sample_framer.md
Name: sample_framer

Overview:
- Upstream stage of the windowing block. Collects a serial stream of WIDTH-bit samples into a packed SIZE-sample frame and presents it with a valid/ready handshake.
- Frame layout: sample k is at frame_data[k*WIDTH +: WIDTH], oldest at k=0. This matches the coefficient indexing of the window stage, which takes frame_data directly as its input function.
- Supports overlapping frames through a hop size: a new frame is emitted every HOP samples after the initial fill.

Parameters:
- SIZE, 8, samples per frame; must be >=2.
- WIDTH, 8, bits per sample.
- HOP, 8, new samples between successive frames after the initial fill; 1<=HOP<=SIZE, and HOP<SIZE gives overlap.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush, active high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  framer can accept a sample.
- s_data  in  WIDTH  input sample.
- frame_valid  out  1  frame_data holds an unconsumed frame.
- frame_ready  in  1  downstream accepts the frame.
- frame_data  out  SIZE*WIDTH  packed frame; oldest sample at index 0.
- frame_seq  out  8  count of emitted frames; wraps 255->0.

Behaviour:
- Reset (rst_n=0, asynchronous): shift register, frame_data, frame_seq and cnt all 0; frame_valid=0; state=FILL.
- Accept: a sample is taken when s_valid && s_ready on a rising edge.
- Shift register sh[0..SIZE-1]: on accept, sh[k] <= sh[k+1] for k<SIZE-1, and sh[SIZE-1] <= s_data.
- Counter cnt, width $clog2(SIZE+1).
- State FILL: each accept increments cnt. The accept that brings the total to SIZE is the trigger. Then state->RUN and cnt<=0.
- State RUN: each accept increments cnt. The accept at cnt==HOP-1 is the trigger; then cnt<=0.
- Trigger, on the same edge:
  - frame_data <= the post-shift register contents, including the new sample at index SIZE-1.
  - frame_valid <= 1.
  - frame_seq <= frame_seq+1.
- Latency: frame_valid is high in the cycle after the completing sample's handshake. frame_data is registered and stable while frame_valid=1.
- Frame handshake: the frame is consumed on an edge with frame_valid && frame_ready. frame_valid drops to 0 unless a trigger occurs on the same edge.
- Simultaneous consume and trigger: the new frame loads, frame_valid stays 1, frame_seq increments once.
- Backpressure (combinational): s_ready = !(frame_valid && !frame_ready && trigger_pending). trigger_pending = the next accept would be a trigger.
  - Samples that do not complete a frame are always accepted.
  - A pending frame is never overwritten.
- s_ready does not depend on s_valid. No sample is ever dropped and no frame is ever lost.
- clear (synchronous, highest priority after reset): state=FILL, cnt=0, frame_valid=0, and any sample presented that cycle is not accepted (s_ready=0 while clear=1).
  - sh and frame_data keep their values but are stale.
  - frame_seq is kept.
- HOP==SIZE: non-overlapping frames. HOP==1: a frame after every sample once filled.
- Reset mid-operation: immediate return to the reset values above. The partial frame is discarded.
- Arithmetic: samples are passed through unmodified, with no sign interpretation. frame_seq wraps modulo 256.

Test Plan:
- SIZE=8, HOP=8, frame_ready=1; feed 1..8 back-to-back -> frame_valid=1 one cycle after the 8th handshake, frame_data bytes [0..7]=1..8, frame_seq=1. Feed 9..16 -> second frame 9..16, frame_seq=2.
- HOP=4; feed 1..12 with frame_ready=1 -> frames [1..8] after sample 8 and [5..12] after sample 12, frame_seq=2.
- HOP=8, frame_ready=0; feed 1..16 continuously -> first frame 1..8 held stable. s_ready=0 when sample 16 is presented. Raise frame_ready -> 16 accepted, next frame 9..16.
- Completing sample and frame_ready=1 on the same edge -> frame_valid stays 1, frame_data updates, and frame_seq increments once.
- clear after 5 samples, then feed 20..27 -> first frame [20..27]. A sample held on s_valid during the clear cycle is not accepted.
- rst_n pulsed low mid-fill (asynchronous, between edges) -> outputs zero immediately. Refill 1..8 -> frame 1..8, frame_seq=1.
